// File: rtl/mux_rr_n_pkg.sv
// Shared types, default sizes and the channel-index wrap helper for mux_rr_n.
package mux_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

  typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} out_state_e;

  localparam int unsigned NChDefault = 8;
  localparam int unsigned WDefault   = 8;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_n_if.sv
// Port bundle for mux_rr_n with design-side and bench-side views.
interface mux_n_if #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned W    = 8,
  parameter int unsigned SW   = $clog2(N_CH)
);
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [SW-1:0]     sel;
  logic              mode;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_ch;

  modport rtl (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport tb (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr_n_rr_pick.sv
// Combinational rotate-priority finder: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            found,
  output logic [SW-1:0]   idx
);

  logic [2*N_CH-1:0] rot;
  logic [SW-1:0]     off;
  logic [SW:0]       sum;

  always_comb begin
    rot   = {req, req} >> ptr;
    found = 1'b0;
    off   = '0;
    // Descending scan so the smallest offset from ptr wins.
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = SW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SW + 1)'(N_CH)) begin
      sum = sum - (SW + 1)'(N_CH);
    end
    idx = sum[SW-1:0];
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered stream selector, fixed or round-robin arbitration.
// Optional out_par (even parity of out_data) enabled by defining MUX_PARITY_EN.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int unsigned N_CH = NChDefault,
  parameter int unsigned W    = WDefault,
  parameter int unsigned SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [SW-1:0]     sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_ch
`ifdef MUX_PARITY_EN
  ,
  output logic              out_par
`endif
);

  out_state_e    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  ch_data [N_CH];
  logic          load, fixed_ok, rr_found, cand_ok, grant;
  logic [SW-1:0] rr_idx, cand;
  mux_mode_e     mode_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  rr_pick #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    mode_e   = mux_mode_e'(mode);
    load     = (state_q == StEmpty) || out_ready;
    // Out-of-range sel behaves as an idle channel.
    fixed_ok = 1'b0;
    if (32'(sel) < N_CH) begin
      fixed_ok = in_valid[sel];
    end
    if (mode_e == MODE_RR) begin
      cand    = rr_idx;
      cand_ok = rr_found;
    end else begin
      cand    = sel;
      cand_ok = fixed_ok;
    end
    grant    = load && cand_ok && !rst;
    in_ready = '0;
    if (grant) begin
      in_ready[cand] = 1'b1;
    end

    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = StFull;
      data_d  = ch_data[cand];
      ch_d    = cand;
      if (mode_e == MODE_RR) begin
        ptr_d = SW'(next_idx(32'(cand), N_CH));
      end
    end else if (load) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

`ifdef MUX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (grant) begin
      par_d = ^ch_data[cand];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_par = par_q;
`endif

endmodule
